// File: rtl/alu_result_queue.sv
// alu_result_queue: in-order ALU result FIFO with valid/ready handoff and sticky overflow; `define ALU_RESQ_BYPASS_EN for zero-latency pass-through when empty
module alu_result_queue #(
  parameter int W = 64,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_O,
  input  logic             in_Ovf,
  input  logic             in_Zero,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_O,
  output logic             out_Ovf,
  output logic             out_Zero,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] count,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int E_W = W + TAG_W + 2;
  logic [E_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic empty, byp, acc, push, pop;
  logic [E_W-1:0] head;
  // handshake decode and head selection; flags come from count alone
  always_comb begin
    empty = count == '0;
    in_ready = count != CNT_W'(DEPTH);
`ifdef ALU_RESQ_BYPASS_EN
    byp = empty && in_valid && out_ready;
`else
    byp = 1'b0;
`endif
    acc = in_valid && in_ready;
    push = acc && !byp;
    pop = !empty && out_ready;
    head = byp ? {in_O, in_Ovf, in_Zero, in_tag} : empty ? '0 : mem[rd_ptr];
    out_valid = !empty || byp;
    {out_O, out_Ovf, out_Zero, out_tag} = head;
  end
  // entry storage, written only on a stored push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_O, in_Ovf, in_Zero, in_tag};
  end
  // pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // sticky overflow, a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (acc && in_Ovf) ovf_sticky <= 1'b1;
    else if (clr_sticky) ovf_sticky <= 1'b0;
  end
endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream of the 64-bit ALU. Captures each ALU result (O, Ovf, Zero) with a destination-register tag into a small in-order FIFO.
- Presents entries to the writeback stage over a valid/ready handshake, so the ALU can keep issuing while writeback stalls.
- Keeps a sticky overflow flag for the exception/status logic.

Parameters:
W, 64, result data width (matches ALU O width)
TAG_W, 5, destination register tag width
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  ALU result valid
in_ready  output  1  queue can accept an entry this cycle
in_O  input  W  ALU result
in_Ovf  input  1  ALU overflow flag
in_Zero  input  1  ALU zero flag
in_tag  input  TAG_W  destination register tag
out_valid  output  1  head entry valid
out_ready  input  1  writeback consumes head
out_O  output  W  head result
out_Ovf  output  1  head overflow flag
out_Zero  output  1  head zero flag
out_tag  output  TAG_W  head tag
count  output  CNT_W  current occupancy, 0..DEPTH
ovf_sticky  output  1  set by any accepted entry with Ovf=1
clr_sticky  input  1  clears ovf_sticky

Behaviour:
- Reset (rst=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0, ovf_sticky=0. Storage contents are don't-care. Reset in mid-operation discards all entries.
- After reset, out_valid=0 and in_ready=1.
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both are evaluated on the same edge.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on out_ready. A full queue does not accept a push even in a pop cycle.
- out_valid = (count != 0), except as modified by the optional feature.
- out_O, out_Ovf, out_Zero, out_tag always show the entry at rd_ptr. They are forced to 0 while count=0.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1 cycle).
- Push only: write entry at wr_ptr; wr_ptr += 1 mod DEPTH; count += 1.
- Pop only: rd_ptr += 1 mod DEPTH; count -= 1.
- Push and pop together (0 < count < DEPTH): both pointers advance and count is unchanged.
- At count=0, a push is a push-only (out_valid=0, so no pop occurs).
- Pointers wrap silently. Data order is strict FIFO.
- Inputs are ignored when in_valid=0, and in_* is never sampled without a push. out_ready is ignored when out_valid=0.
- ovf_sticky: set on any push with in_Ovf=1; cleared by clr_sticky=1. If a set and a clear occur in the same cycle, set wins.
- No state machine beyond pointer/count. The full/empty flags are derived from count only; there are no separate flag registers.

Optional Feature:
- Macro: ALU_RESQ_BYPASS_EN.
- Defined: when count=0, in_valid=1 and out_ready=1, the input passes straight through in the same cycle (zero latency).
  - out_valid=1 and out_* = in_*.
  - The entry is not written, and pointers and count are unchanged.
  - in_ready is unchanged, since count=0 implies in_ready=1.
  - ovf_sticky updates as for a normal push.
  - If count=0, in_valid=1 and out_ready=0, the entry is stored normally.
- Not defined: no combinational in-to-out path. out_valid depends only on count, and latency is always 1 cycle.

Test Plan:
1. Reset with in_valid=1 held → count=0, out_valid=0, in_ready=1, ovf_sticky=0, out_O=0 during and after reset.
2. Push O=12 (ALU 7+5, OP=0010), Ovf=0, Zero=0, tag=3, with out_ready=0 → next cycle out_valid=1, out_O=12, out_tag=3, count=1. Raise out_ready → count=0, out_valid=0.
3. Push 4 entries tagged 1..4 with out_ready=0 → count=4, in_ready=0. A 5th in_valid is ignored. Drain → tags appear 1,2,3,4 in order.
4. Hold count=2 and drive push and pop every cycle for 10 cycles (tags 10..19) → count stays 2, output order matches input order, pointers wrap without error.
5. Push O=0x8000000000000000 with Ovf=1 → ovf_sticky=1 next cycle. clr_sticky=1 alone → 0. clr_sticky=1 together with another Ovf=1 push → stays 1.
6. With ALU_RESQ_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_O=0x55, tag=7 → same cycle out_valid=1, out_O=0x55, out_tag=7; count stays 0. Without the macro → out_valid=0 that cycle, entry visible next cycle.
